// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the halfword-sequencing SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_DQ_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    typedef enum logic {
        RD,
        WR
    } op_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter; flags the final cycle of a halfword access.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic last
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign last = (r_cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller: splits each 32-bit load/store into two 16-bit
// SRAM accesses (low half first) and freezes the pipeline meanwhile.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_ADDR_W = 17,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DQ_W-1:0]   sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
    output logic                   sram_we_n
);

    state_t                 r_state;
    state_t                 w_next;
    op_t                    r_op;
    logic [SRAM_ADDR_W-2:0] r_word;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   w_req;
    logic                   w_busy;
    logic                   w_last;
    logic                   w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_busy   = (r_state == LO) || (r_state == HI);
    assign w_unused = ^{addr[31:SRAM_ADDR_W+1], addr[1:0]};

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(!w_busy || w_last),
        .en   (w_busy),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_req) w_next = LO;
            LO:   if (w_last) w_next = HI;
            HI:   if (w_last) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read wins when both strobes are high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= RD;
            r_word  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_req) begin
            r_op    <= mem_read ? RD : WR;
            r_word  <= addr[SRAM_ADDR_W:2];
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_op == RD && w_last) begin
            if (r_state == LO) r_rdata[15:0] <= sram_dq_in;
            if (r_state == HI) r_rdata[31:16] <= sram_dq_in;
        end
    end

    assign rdata = r_rdata;
    assign ready = (r_state == IDLE && !w_req) || (r_state == DONE);

    // we_n rises on the last cycle of each phase to give data hold time.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        unique case (r_state)
            LO: begin
                sram_addr = {r_word, 1'b0};
                if (r_op == WR) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[15:0];
                    sram_we_n   = w_last;
                end
            end
            HI: begin
                sram_addr = {r_word, 1'b1};
                if (r_op == WR) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[31:16];
                    sram_we_n   = w_last;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences every MEM-stage load and store onto a shared 16-bit external SRAM.
- Each 32-bit word is split into two halfword accesses, low half first.
- The controller holds the pipeline frozen via `ready` until the access completes.
- It sits between the EXE/MEM pipeline register and the SRAM pins, and is driven by the decoded `mem_read`/`mem_write` strobes.

## Interface
Parameters:
- `SRAM_ADDR_W`, 17: halfword address width of the SRAM.
- `WAIT_CYCLES`, 3: cycles per halfword access. Legal range 2..15.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; synchronous, active-low
- `mem_read`  in  1  load request from MEM stage, level, held while `ready`=0
- `mem_write`  in  1  store request from MEM stage, level, held while `ready`=0
- `addr`  in  32  byte address; bits [1:0] ignored
- `wdata`  in  32  store data
- `rdata`  out  32  load result
- `ready`  out  1  0 = freeze pipeline
- `sram_addr`  out  SRAM_ADDR_W  halfword address
- `sram_dq_out`  out  16  write data to pad
- `sram_dq_oe`  out  1  pad output enable
- `sram_dq_in`  in  16  read data from pad
- `sram_we_n`  out  1  write enable, active-low

## Operation
States: IDLE, LO, HI, DONE.

IDLE
- `mem_read`|`mem_write` sampled.
- On a request: latch `addr[SRAM_ADDR_W:2]`, `wdata` and the op, then go to LO.
- Both strobes high: treated as read; write ignored.

LO
- `sram_addr` = {word, 1'b0}.
- Stays WAIT_CYCLES cycles, counted by a wait counter from 0 to WAIT_CYCLES-1, then goes to HI with the counter cleared.

HI
- `sram_addr` = {word, 1'b1}.
- Stays WAIT_CYCLES cycles, then goes to DONE.

DONE
- Lasts one cycle, then returns to IDLE unconditionally.
- Requests are not sampled in DONE, because the strobes still belong to the completing instruction.

Read behaviour
- `sram_we_n`=1 and `sram_dq_oe`=0.
- `sram_dq_in` is captured on the last counter cycle of LO into `rdata[15:0]` and of HI into `rdata[31:16]`.
- `rdata` holds its value otherwise; writes never modify it.

Write behaviour
- `sram_dq_oe`=1 throughout LO/HI.
- `sram_dq_out` = `wdata[15:0]` in LO and `wdata[31:16]` in HI.
- `sram_we_n`=0 on all phase cycles except the last of each phase, where it is 1 for data hold.

Ready and idle outputs
- `ready` = (IDLE and no request) or DONE. It is combinational from state and strobes.
- In IDLE/DONE: `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces:
  - state IDLE, counter 0;
  - `rdata`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
- Reset asserted mid-access aborts the access. No further `sram_we_n` pulse occurs and `rdata` is cleared.
- Request first seen in IDLE at cycle t:
  - `ready`=0 in cycles t .. t+2·WAIT_CYCLES;
  - DONE at cycle t+2·WAIT_CYCLES+1 with `ready`=1.
  - Freeze length is 2·WAIT_CYCLES+1 cycles (7 at default).
- `rdata` is valid from the DONE cycle and stable until the next read completes.
- Back-to-back accesses: a request at the cycle after DONE starts immediately. There are no bubbles beyond DONE.
- No request in IDLE: `ready`=1 every cycle and the SRAM pins stay idle.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the op type (RD, WR);
  - the constant `SRAM_DQ_W`=16.
- Sub-module `sram_wait_counter`:
  - 4-bit counter with `clear`/`en`;
  - outputs `last` when count equals WAIT_CYCLES-1;
  - synchronous active-low reset.

## Test plan
- **Idle:** no strobes for 10 cycles → `ready`=1 throughout, `sram_we_n`=1, `sram_dq_oe`=0.
- **Read:** `mem_read`, `addr`=0x10, SRAM model returns 0xBEEF at halfword 8 and 0xDEAD at halfword 9 → `ready` low 7 cycles, then `rdata`=0xDEADBEEF in DONE.
- **Write:** `mem_write`, `addr`=0x20, `wdata`=0x12345678 → halfword 16 gets 0x5678 and halfword 17 gets 0x1234; `sram_we_n` low exactly 2 cycles per phase; `rdata` unchanged.
- **Back-to-back:** write followed immediately by read of the same address → second access starts the cycle after DONE; read returns 0x12345678.
- **Both strobes:** `mem_read`=`mem_write`=1 → read-only behaviour; `sram_we_n` never asserts.
- **Reset mid-access:** `rst_n`=0 during HI of a write → next cycle IDLE, `sram_we_n`=1, `rdata`=0; subsequent read works normally.
